// File: rtl/sx_bus_pkg.sv
// rtl/sx_bus_pkg.sv - shared types, constants and cycle decode for the 386SX bus target
package sx_bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    REQ  = 3'd2,
    ACK  = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CYC_MEM,
    CYC_IO,
    CYC_INTA,
    CYC_SPECIAL
  } cyc_t;

  localparam int          TMR_W      = 10;
  localparam logic [15:0] DATA_FLOAT = 16'hFFFF;

  // The reserved {mio,dc,wr}=3'b001 encoding is treated as I/O, so it only
  // responds when it falls inside the window.
  function automatic cyc_t decode_cycle(input logic mio, input logic dc, input logic wr);
    if (mio && !dc && wr) return CYC_SPECIAL;
    if (mio)              return CYC_MEM;
    if (dc)               return CYC_IO;
    if (!wr)              return CYC_INTA;
    return CYC_IO;
  endfunction

endpackage

// File: rtl/sx_cycle_timer.sv
// rtl/sx_cycle_timer.sv - loadable saturating down-counter with zero flag
module sx_cycle_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sx_bus_target.sv
// rtl/sx_bus_target.sv - 386SX local-bus target: decode, wait states, backend handoff, READY_n
module sx_bus_target
  import sx_bus_pkg::*;
#(
  parameter int                ADDR_W       = 24,
  parameter int                DATA_W       = 16,
  parameter int                WAIT_STATES  = 1,
  parameter logic [ADDR_W-1:0] WIN_BASE     = 24'hFF0000,
  parameter logic [ADDR_W-1:0] WIN_MASK     = 24'hFF0000,
  parameter int                TIMEOUT      = 64,
  parameter logic [7:0]        IACK_VECTOR  = 8'h08,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 24'hFFFFF0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ads_n,
  input  logic              mio,
  input  logic              dc,
  input  logic              wr,
  input  logic              bhe_n,
  input  logic              ble_n,
  input  logic [ADDR_W-2:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              ready_n,
  output logic              ready_oe,
  output logic              na_n,
  output logic              bk_req,
  output logic              bk_wr,
  output logic [ADDR_W-2:0] bk_addr,
  output logic [1:0]        bk_be,
  output logic [DATA_W-1:0] bk_wdata,
  input  logic              bk_ack,
  input  logic [DATA_W-1:0] bk_rdata,
  input  logic              err_clr,
  output logic              bus_err,
  output logic              rv_hit,
  output logic [2:0]        state_dbg
);

  state_t            state_q, state_d;
  cyc_t              cyc_q, cyc_in;
  logic [ADDR_W-1:0] full_addr;
  logic              win_hit, ads_take, bypass;
  logic              tmr_load, tmr_en, tmr_zero;
  logic [TMR_W-1:0]  tmr_val;
  logic              timeout_hit, rv_fetch;

  assign cyc_in      = decode_cycle(mio, dc, wr);
  assign full_addr   = {addr, 1'b0};
  assign win_hit     = ((full_addr & WIN_MASK) == (WIN_BASE & WIN_MASK));
  assign ads_take    = (state_q == IDLE) && !ads_n;
  assign bypass      = (cyc_q == CYC_INTA) || (cyc_q == CYC_SPECIAL);
  assign tmr_en      = (state_q == WAIT) || (state_q == REQ);
  assign timeout_hit = (state_q == REQ) && tmr_zero && !bk_ack;
  assign rv_fetch    = ads_take && mio && dc && !wr && (addr == RESET_VECTOR[ADDR_W-1:1]);

  // One counter serves both phases: WAIT loads the wait-state count, REQ the timeout.
  sx_cycle_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (ads_take && ((cyc_in == CYC_INTA) || (cyc_in == CYC_SPECIAL) || win_hit)) begin
          state_d  = WAIT;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(WAIT_STATES);
        end
      end
      WAIT: begin
        if (tmr_zero) begin
          if (bypass) begin
            state_d = ACK;
          end else begin
            state_d  = REQ;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(TIMEOUT - 1);
          end
        end
      end
      REQ:     if (bk_ack || tmr_zero) state_d = ACK;
      ACK:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q    <= CYC_MEM;
      bk_addr  <= '0;
      bk_be    <= '0;
      bk_wr    <= 1'b0;
      bk_wdata <= '0;
      data_out <= '0;
      bus_err  <= 1'b0;
      rv_hit   <= 1'b0;
    end else begin
      if (ads_take) begin
        cyc_q   <= cyc_in;
        bk_addr <= addr;
        bk_be   <= {~bhe_n, ~ble_n};
        bk_wr   <= wr;
      end
      if ((state_q == WAIT) && (state_d == REQ)) bk_wdata <= data_in;
      if ((state_q == WAIT) && (state_d == ACK) && (cyc_q == CYC_INTA))
        data_out <= DATA_W'({8'h00, IACK_VECTOR});
      if (state_q == REQ) begin
        if (bk_ack)        data_out <= bk_rdata;
        else if (tmr_zero) data_out <= DATA_W'(DATA_FLOAT);
      end
      // A timeout landing with err_clr keeps the flag set.
      if (timeout_hit)  bus_err <= 1'b1;
      else if (err_clr) bus_err <= 1'b0;
      if (rv_fetch) rv_hit <= 1'b1;
    end
  end

  assign ready_n   = (state_q != ACK);
  assign ready_oe  = (state_q == ACK);
  assign data_oe   = (state_q == ACK) && !bk_wr && (cyc_q != CYC_SPECIAL);
  assign bk_req    = (state_q == REQ);
  assign na_n      = 1'b1;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sx_bus_target.sv
// tb/tb_sx_bus_target.sv - randomized self-checking bench for sx_bus_target
module tb_sx_bus_target;

  localparam int          WS     = 1;
  localparam int          TMO    = 8;
  localparam logic [23:0] W_BASE = 24'hFF0000;
  localparam logic [23:0] W_MASK = 24'hFF0000;
  localparam logic [23:0] RV     = 24'hFFFFF0;
  localparam logic [2:0]  ST_IDLE = 3'd0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ads_n = 1'b1, mio = 1'b0, dc = 1'b0, wr = 1'b0, bhe_n = 1'b1, ble_n = 1'b1;
  logic [22:0] addr = '0;
  logic [15:0] data_in = '0, data_out;
  logic        data_oe, ready_n, ready_oe, na_n, bk_req, bk_wr;
  logic [22:0] bk_addr;
  logic [1:0]  bk_be;
  logic [15:0] bk_wdata, bk_rdata = '0;
  logic        bk_ack = 1'b0, err_clr = 1'b0, bus_err, rv_hit;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int txn_id   = 0;

  logic [15:0] exp_dout = '0;
  logic        exp_err  = 1'b0;
  logic        exp_rv   = 1'b0;

  sx_bus_target #(
    .WAIT_STATES (WS),
    .TIMEOUT     (TMO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ads_n     (ads_n),
    .mio       (mio),
    .dc        (dc),
    .wr        (wr),
    .bhe_n     (bhe_n),
    .ble_n     (ble_n),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .ready_n   (ready_n),
    .ready_oe  (ready_oe),
    .na_n      (na_n),
    .bk_req    (bk_req),
    .bk_wr     (bk_wr),
    .bk_addr   (bk_addr),
    .bk_be     (bk_be),
    .bk_wdata  (bk_wdata),
    .bk_ack    (bk_ack),
    .bk_rdata  (bk_rdata),
    .err_clr   (err_clr),
    .bus_err   (bus_err),
    .rv_hit    (rv_hit),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s txn=%0d got=%0h exp=%0h", tag, txn_id, got, exp);
    end
  endtask

  // One CPU bus cycle. ack_dly: backend asserts bk_ack that many cycles after
  // bk_req rises (<=0 means never). clr_edge: edge index (ads sample = 0) at
  // which err_clr is sampled high (<0 means none).
  task automatic run_cycle(input logic [22:0] a, input logic m, input logic d_c, input logic w,
                           input logic bh, input logic bl, input logic [15:0] wd,
                           input int ack_dly, input logic [15:0] rd, input bit spur,
                           input int clr_edge);
    logic [23:0] fa;
    bit          hit, accepted, is_inta, is_special, ack_ok, tmo;
    int          r_edge, ack_edge, last;
    int          req_first, req_cnt, rdy_first, rdy_cnt, stray_oe, oe_bad;
    logic [15:0] ack_dout, s_wd;
    logic        ack_doe, s_wr;
    logic [22:0] s_addr;
    logic [1:0]  s_be;

    txn_id++;
    fa         = {a, 1'b0};
    hit        = ((fa & W_MASK) == (W_BASE & W_MASK));
    is_special = m && !d_c && w;
    is_inta    = !m && !d_c && !w;
    accepted   = is_special || is_inta || hit;
    ack_ok     = (ack_dly >= 1) && (ack_dly + 1 <= TMO);
    r_edge     = WS + 1;
    if (is_special || is_inta) ack_edge = WS + 1;
    else if (ack_ok)           ack_edge = r_edge + ack_dly + 1;
    else                       ack_edge = r_edge + TMO;
    last = accepted ? ack_edge + 2 : 2;
    tmo  = accepted && !is_special && !is_inta && !ack_ok;

    req_first = -1; req_cnt = 0; rdy_first = -1; rdy_cnt = 0; stray_oe = 0; oe_bad = 0;
    ack_dout = '0; ack_doe = 1'b0; s_wd = '0; s_wr = 1'b0; s_addr = '0; s_be = '0;

    @(posedge clk); #1;
    ads_n = 1'b0; addr = a; mio = m; dc = d_c; wr = w; bhe_n = bh; ble_n = bl;
    data_in = wd; bk_rdata = rd;
    @(posedge clk); #1;
    ads_n = 1'b1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (bk_req) begin
        if (req_first < 0) begin
          req_first = k; s_addr = bk_addr; s_be = bk_be; s_wr = bk_wr; s_wd = bk_wdata;
        end
        req_cnt++;
      end
      if (!ready_n) begin
        rdy_cnt++; rdy_first = k; ack_dout = data_out; ack_doe = data_oe;
      end else if (data_oe) begin
        stray_oe++;
      end
      if (ready_oe !== !ready_n) oe_bad++;
      if (k == last) check_eq("state_end", 32'(state_dbg), 32'(ST_IDLE));
      @(posedge clk); #1;
      bk_ack  = ack_ok && (req_first >= 0) && (k + 1 == req_first + ack_dly);
      err_clr = (k + 2 == clr_edge);
      if (spur && accepted && k == 0) begin ads_n = 1'b0; addr = 23'($urandom); end
      else ads_n = 1'b1;
    end
    bk_ack = 1'b0; err_clr = 1'b0; ads_n = 1'b1;

    if (accepted) begin
      if (is_inta)       exp_dout = 16'h0008;
      else if (!is_special) exp_dout = ack_ok ? rd : 16'hFFFF;
    end
    if (tmo)                exp_err = 1'b1;
    else if (clr_edge >= 0) exp_err = 1'b0;
    if (m && d_c && !w && (a == RV[23:1])) exp_rv = 1'b1;

    check_eq("rdy_cnt", 32'(rdy_cnt), accepted ? 32'd1 : 32'd0);
    check_eq("req_cnt", 32'(req_cnt),
             (accepted && !is_special && !is_inta) ? 32'(ack_edge - r_edge) : 32'd0);
    check_eq("stray_oe", 32'(stray_oe), 32'd0);
    check_eq("ready_oe", 32'(oe_bad), 32'd0);
    if (accepted) begin
      check_eq("rdy_edge", 32'(rdy_first), 32'(ack_edge));
      check_eq("dout", 32'(ack_dout), 32'(exp_dout));
      check_eq("data_oe", 32'(ack_doe), 32'(!w && !is_special));
    end
    if (accepted && !is_special && !is_inta) begin
      check_eq("req_edge", 32'(req_first), 32'(r_edge));
      check_eq("bk_addr", 32'(s_addr), 32'(a));
      check_eq("bk_be", 32'(s_be), 32'({~bh, ~bl}));
      check_eq("bk_wr", 32'(s_wr), 32'(w));
      check_eq("bk_wdata", 32'(s_wd), 32'(wd));
    end
    check_eq("bus_err", 32'(bus_err), 32'(exp_err));
    check_eq("rv_hit", 32'(rv_hit), 32'(exp_rv));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog txn=%0d", txn_id);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [22:0] ra;
    logic [2:0]  rc;
    int          rdly, rclr;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_dout", 32'(data_out), 32'd0);
    check_eq("rst_oe", 32'({data_oe, ready_oe, bk_req, bk_wr}), 32'd0);
    check_eq("rst_ready_n", 32'({ready_n, na_n}), 32'b11);
    check_eq("rst_bk", 32'({bk_addr, bk_be}), 32'd0);
    check_eq("rst_wdata", 32'(bk_wdata), 32'd0);
    check_eq("rst_flags", 32'({bus_err, rv_hit}), 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));

    // reset vector fetch, write hit, window miss
    run_cycle(23'(RV >> 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 2, 16'hEA5B, 1'b0, -1);
    run_cycle(23'(24'hFF0010 >> 1), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 1, 16'h0, 1'b0, -1);
    run_cycle(23'(24'h001000 >> 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1, 16'h5555, 1'b0, -1);
    // timeout, then standalone clear
    run_cycle(23'(24'hFF0200 >> 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 0, 16'h0, 1'b0, -1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    check_eq("err_clr", 32'(bus_err), 32'd0);
    // ack on the expiry cycle, then timeout coinciding with err_clr
    run_cycle(23'(24'hFF0300 >> 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, TMO - 1, 16'hC0DE, 1'b0, -1);
    run_cycle(23'(24'hFF0400 >> 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 0, 16'h0, 1'b0, WS + 1 + TMO);
    // INTA and halt
    run_cycle(23'h000002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 0, 16'h0, 1'b0, -1);
    run_cycle(23'h000001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 0, 16'h0, 1'b1, -1);

    // asynchronous reset while waiting on the backend
    @(posedge clk); #1;
    ads_n = 1'b0; addr = 23'(24'hFF0500 >> 1); mio = 1'b1; dc = 1'b1; wr = 1'b0;
    @(posedge clk); #1 ads_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("pre_rst_req", 32'(bk_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_req", 32'({bk_req, ready_oe, data_oe}), 32'd0);
    check_eq("arst_state", 32'(state_dbg), 32'(ST_IDLE));
    check_eq("arst_flags", 32'({rv_hit, bus_err}), 32'd0);
    check_eq("arst_dout", 32'(data_out), 32'd0);
    exp_dout = '0; exp_err = 1'b0; exp_rv = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    run_cycle(23'(24'hFF0600 >> 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 3, 16'h6A6A, 1'b0, -1);

    for (int i = 0; i < 60; i++) begin
      ra = 23'($urandom);
      if ($urandom_range(0, 1) == 1) ra[22:15] = 8'hFF;
      if ($urandom_range(0, 15) == 0) ra = 23'(RV >> 1);
      do rc = 3'($urandom_range(0, 7)); while (rc == 3'b001);
      rdly = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, TMO - 1);
      rclr = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 4) : -1;
      run_cycle(ra, rc[2], rc[1], rc[0], 1'($urandom), 1'($urandom), 16'($urandom),
                rdly, 16'($urandom), ($urandom_range(0, 3) == 0), rclr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
